// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer and the pipeline registers it controls.
//   hz_state_e  : sequencer state encoding
//   pipe_ctrl_t : bundle of PC / IF/ID / ID/EX / global hold controls
//   run_ctrl()  : control bundle for a non-holding cycle
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic pipe_hold;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_FLOW     = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0, pipe_hold: 1'b0};
    localparam pipe_ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1, pipe_hold: 1'b0};
    localparam pipe_ctrl_t CTRL_BUBBLE   = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b1, pipe_hold: 1'b0};
    localparam pipe_ctrl_t CTRL_HOLD     = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_flush: 1'b0, pipe_hold: 1'b1};
    localparam pipe_ctrl_t CTRL_RESET    = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1, id_ex_flush: 1'b1, pipe_hold: 1'b0};

    // Redirect wins over load-use: the flush kills the dependent instruction anyway.
    function automatic pipe_ctrl_t run_ctrl(input logic redirect, input logic load_use);
        pipe_ctrl_t c;
        if (redirect)      c = CTRL_REDIRECT;
        else if (load_use) c = CTRL_BUBBLE;
        else               c = CTRL_FLOW;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the instruction in ID and the load in EX.
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : ID source operands
//   id_ex_mem_read, id_ex_rd               : EX instruction is a load, and its rd
//   load_use                               : ID must wait one cycle for the load data
import pipe_ctrl_pkg::*;

module hazard_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       id_ex_mem_read,
    input  logic [4:0] id_ex_rd,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == id_ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == id_ex_rd);
    // x0 is hard-wired zero, so a load targeting it never produces a hazard.
    assign load_use = id_ex_mem_read && (id_ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use bubbles, EX redirects,
// data-memory wait with bounded timeout, and a saturating stall counter.
//   clk, reset_n          : clock, async active-low reset
//   id_* / id_ex_*        : hazard-compare operands
//   ex_redirect           : EX resolved a taken control transfer
//   mem_req, mem_ready    : MEM stage access and completion
//   pc_write..pipe_hold   : pipeline register controls (combinational)
//   mem_timeout           : sticky memory timeout flag
//   stall_count           : cycles with pc_write low, saturating
//
// state    | meaning
// RUN      | normal flow; bubbles and redirects applied
// MEM_WAIT | pipe frozen waiting for mem_ready, wait_cnt counts stalled cycles
// ERROR    | memory timed out; pipe frozen until reset
import pipe_ctrl_pkg::*;

module pipeline_hazard_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic                   id_ex_mem_read,
    input  logic [4:0]             id_ex_rd,
    input  logic                   ex_redirect,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   pipe_hold,
    output logic                   mem_timeout,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    hz_state_e   state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic        timeout_nxt;
    logic        load_use;
    logic        mem_wait;
    pipe_ctrl_t  ctrl;

    hazard_detect u_hazard_detect (
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rd       (id_ex_rd),
        .load_use       (load_use)
    );

    assign mem_wait = mem_req && !mem_ready;

    always_comb begin
        ctrl        = CTRL_HOLD;
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        timeout_nxt = mem_timeout;
        case (state)
            RUN: begin
                if (mem_wait) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else begin
                    ctrl = run_ctrl(ex_redirect, load_use);
                end
            end
            MEM_WAIT: begin
                // EX is frozen while holding, so a redirect or hazard seen now
                // will re-present on the release cycle.
                if (mem_ready) begin
                    ctrl      = run_ctrl(ex_redirect, load_use);
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt < WAIT_W'(MEM_WAIT_MAX)) begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end else begin
                    state_nxt   = ERROR;
                    timeout_nxt = 1'b1;
                end
            end
            ERROR:   state_nxt = ERROR;
            default: state_nxt = ERROR;
        endcase
        if (!reset_n) ctrl = CTRL_RESET;
    end

    assign pc_write    = ctrl.pc_write;
    assign if_id_write = ctrl.if_id_write;
    assign if_id_flush = ctrl.if_id_flush;
    assign id_ex_flush = ctrl.id_ex_flush;
    assign pipe_hold   = ctrl.pipe_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_count <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            mem_timeout <= timeout_nxt;
            if (!ctrl.pc_write && (stall_count != '1))
                stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized traffic, compared each cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int MAX_WAIT = 15;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_ex_rd = '0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_ex_mem_read = 1'b0;
    logic       ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_timeout;
    logic [15:0] stall_count;
    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_pipe_hold, s_mem_timeout;
    logic [3:0]  s_stall_count;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_WAIT_MAX(MAX_WAIT), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .pipe_hold(pipe_hold), .mem_timeout(mem_timeout),
        .stall_count(stall_count)
    );

    pipeline_hazard_ctrl #(.MEM_WAIT_MAX(MAX_WAIT), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
        .id_ex_flush(s_id_ex_flush), .pipe_hold(s_pipe_hold), .mem_timeout(s_mem_timeout),
        .stall_count(s_stall_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: timeout after MAX_WAIT+1 consecutive memory-stalled cycles.
    bit m_err;
    bit m_waiting;
    int m_wait_len;
    int m_stalls;

    localparam logic [4:0] E_FLOW     = 5'b11000;
    localparam logic [4:0] E_REDIRECT = 5'b11110;
    localparam logic [4:0] E_BUBBLE   = 5'b00010;
    localparam logic [4:0] E_HOLD     = 5'b00001;
    localparam logic [4:0] E_RESET    = 5'b00110;

    function automatic bit model_mem_hold();
        if (m_err) return 1'b0;
        if (m_waiting) return !mem_ready;
        return mem_req && !mem_ready;
    endfunction

    function automatic logic [4:0] model_ctrl();
        bit lu;
        lu = id_ex_mem_read && (id_ex_rd != 5'd0) &&
             ((id_uses_rs1 && id_rs1 == id_ex_rd) || (id_uses_rs2 && id_rs2 == id_ex_rd));
        if (m_err || model_mem_hold()) return E_HOLD;
        if (ex_redirect) return E_REDIRECT;
        if (lu) return E_BUBBLE;
        return E_FLOW;
    endfunction

    task automatic model_reset();
        m_err = 0; m_waiting = 0; m_wait_len = 0; m_stalls = 0;
    endtask

    function automatic logic [31:0] sat(input int v, input int lim);
        return (v > lim) ? 32'(lim) : 32'(v);
    endfunction

    // Inputs are set after a negedge; one call covers one clock cycle.
    task automatic step();
        logic [4:0] e;
        bit hold;
        #1;
        e    = model_ctrl();
        hold = model_mem_hold();
        chk("ctrl", {27'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}, {27'd0, e});
        chk("ctrl_w4", {27'd0, s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_pipe_hold}, {27'd0, e});
        @(posedge clk);
        if (!e[4]) m_stalls++;
        if (!m_err) begin
            if (hold) begin
                m_wait_len++;
                m_waiting = 1;
                if (m_wait_len == MAX_WAIT + 1) m_err = 1;
            end else begin
                m_waiting  = 0;
                m_wait_len = 0;
            end
        end
        #1;
        chk("stall_count", {16'd0, stall_count}, sat(m_stalls, 65535));
        chk("stall_count_w4", {28'd0, s_stall_count}, sat(m_stalls, 15));
        chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_err});
        @(negedge clk);
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic mrd, input logic [4:0] rd, input logic redir,
                          input logic req, input logic rdy);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_ex_mem_read = mrd; id_ex_rd = rd; ex_redirect = redir; mem_req = req; mem_ready = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        model_reset();
        #1;
        chk("reset_ctrl", {27'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}, {27'd0, E_RESET});
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset_ctrl_init", {27'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}, {27'd0, E_RESET});
        chk("reset_stall", {16'd0, stall_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;

        // Load-use on rs2 gives one bubble, then flows.
        set_in(5'd1, 5'd5, 0, 1, 1, 5'd5, 0, 0, 0); step();
        chk("lu_count", {16'd0, stall_count}, 32'd1);
        set_in(5'd1, 5'd2, 0, 1, 0, 5'd0, 0, 0, 0); step();
        // Same operands but rd = x0: no stall.
        set_in(5'd1, 5'd0, 0, 1, 1, 5'd0, 0, 0, 0); step();
        chk("x0_pc_write", {31'd0, pc_write}, 32'd1);
        chk("x0_count", {16'd0, stall_count}, 32'd1);
        // Redirect overrides load-use.
        set_in(5'd1, 5'd5, 0, 1, 1, 5'd5, 1, 0, 0); step();
        chk("redir_count", {16'd0, stall_count}, 32'd1);

        // Three-cycle memory wait with a redirect pulse during the hold.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); step();
        chk("memwait_count", {16'd0, stall_count}, 32'd4);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("memwait_run", {31'd0, pc_write}, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            id_rs1         = 5'($urandom_range(0, 3));
            id_rs2         = 5'($urandom_range(0, 3));
            id_uses_rs1    = 1'($urandom_range(0, 1));
            id_uses_rs2    = 1'($urandom_range(0, 1));
            id_ex_mem_read = 1'($urandom_range(0, 1));
            id_ex_rd       = 5'($urandom_range(0, 3));
            ex_redirect    = ($urandom_range(0, 3) == 0);
            mem_req        = ($urandom_range(0, 2) == 0);
            mem_ready      = ($urandom_range(0, 3) != 0);
            step();
        end

        // Timeout: 20 cycles of waiting, then ready rises; still held and sticky.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
            step();
            if (i == 14) chk("no_timeout_15", {31'd0, mem_timeout}, 32'd0);
            if (i == 15) chk("timeout_16", {31'd0, mem_timeout}, 32'd1);
        end
        chk("sat_w4", {28'd0, s_stall_count}, 32'd15);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 1, 1);
            step();
        end
        chk("err_hold", {31'd0, pipe_hold}, 32'd1);
        chk("err_sticky", {31'd0, mem_timeout}, 32'd1);
        while (m_stalls < 40) step();
        chk("err_count40", {16'd0, stall_count}, 32'd40);

        // Asynchronous reset in mid-cycle while in ERROR.
        #3;
        reset_n = 0;
        model_reset();
        #1;
        chk("async_ctrl", {27'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}, {27'd0, E_RESET});
        chk("async_count", {16'd0, stall_count}, 32'd0);
        chk("async_timeout", {31'd0, mem_timeout}, 32'd0);
        @(negedge clk);
        reset_n = 1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("post_reset_run", {31'd0, pc_write}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
